regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_sb_read_port.sv | 55 +++++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : shared defaults and address type for regfile_sb         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int RF_DEPTH_DEF = 32;
    localparam int RF_WIDTH_DEF = 32;
    localparam int RF_NRP_MAX   = 4;
    localparam int RF_AW_DEF    = $clog2(RF_DEPTH_DEF);

    typedef logic [RF_AW_DEF-1:0] reg_addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_sb_if : write, read, issue and hazard signals of regfile_sb   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface regfile_sb_if #(
    parameter int DEPTH = regfile_pkg::RF_DEPTH_DEF,
    parameter int WIDTH = regfile_pkg::RF_WIDTH_DEF,
    parameter int NRP   = 2
) ();
    localparam int AW = $clog2(DEPTH);

    logic                       WE0;
    logic [AW-1:0]              WA0;
    logic [WIDTH-1:0]           WD0;
    logic                       WE1;
    logic [AW-1:0]              WA1;
    logic [WIDTH-1:0]           WD1;
    logic [NRP-1:0][AW-1:0]     RA;
    logic [NRP-1:0][WIDTH-1:0]  RD;
    logic                       ISSUE_EN;
    logic [AW-1:0]              ISSUE_RD;
    logic [NRP-1:0]             BUSY;
    logic                       STALL;

    modport master (
        output WE0, WA0, WD0, WE1, WA1, WD1, RA, ISSUE_EN, ISSUE_RD,
        input  RD, BUSY, STALL
    );

    modport slave (
        input  WE0, WA0, WD0, WE1, WA1, WD1, RA, ISSUE_EN, ISSUE_RD,
        output RD, BUSY, STALL
    );

endinterface : regfile_sb_if
`default_nettype wire

// File: rtl/regfile_sb_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_read_port : one read port -- zero-register mask, write forwarding  |
// |                and busy-bit masking for a forwarded write             |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int AW     = RF_AW_DEF,
    parameter int WIDTH  = RF_WIDTH_DEF,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]    ra_i,
    input  logic [WIDTH-1:0] stored_i,
    input  logic             busy_bit_i,
    input  logic             we0_i,
    input  logic [AW-1:0]    wa0_i,
    input  logic [WIDTH-1:0] wd0_i,
    input  logic             we1_i,
    input  logic [AW-1:0]    wa1_i,
    input  logic [WIDTH-1:0] wd1_i,
    output logic [WIDTH-1:0] rd_o,
    output logic             busy_o
);

    logic hit0_w;
    logic hit1_w;
    logic fwd_en_w;

    assign hit0_w   = we0_i && (wa0_i == ra_i);
    assign hit1_w   = we1_i && (wa1_i == ra_i);
    assign fwd_en_w = (BYPASS != 0);

    always_comb begin
        rd_o   = stored_i;
        busy_o = busy_bit_i;
        if (ra_i == '0) begin
            rd_o   = '0;
            busy_o = 1'b0;
        end else if (fwd_en_w) begin
            // Port 1 (load writeback) has priority, matching the storage order.
            if (hit1_w) begin
                rd_o = wd1_i;
            end else if (hit0_w) begin
                rd_o = wd0_i;
            end
            if (hit0_w || hit1_w) begin
                busy_o = 1'b0;
            end
        end
    end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_sb : 2-write / NRP-read register file with a per-register     |
// |              busy scoreboard for issue-time hazard detection          |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int WIDTH  = RF_WIDTH_DEF,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  wire logic   CLK,
    input  wire logic   aRSTn,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]          regs_q [DEPTH];
    logic [DEPTH-1:0]          busy_q;
    logic [DEPTH-1:0]          busy_d;
    logic [NRP-1:0][AW-1:0]    ra_w;
    logic [NRP-1:0][WIDTH-1:0] rd_w;
    logic [NRP-1:0]            busy_w;

    assign ra_w = bus.RA;

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (!aRSTn) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            if (bus.WE0 && (bus.WA0 != '0)) begin
                regs_q[bus.WA0] <= bus.WD0;
            end
            if (bus.WE1 && (bus.WA1 != '0)) begin
                regs_q[bus.WA1] <= bus.WD1;
            end
        end
    end

    // Clears first, then the issue set, so a same-cycle issue leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (bus.WE0) begin
            busy_d[bus.WA0] = 1'b0;
        end
        if (bus.WE1) begin
            busy_d[bus.WA1] = 1'b0;
        end
        if (bus.ISSUE_EN) begin
            busy_d[bus.ISSUE_RD] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!aRSTn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rd_port
        rf_read_port #(
            .AW     (AW),
            .WIDTH  (WIDTH),
            .BYPASS (BYPASS)
        ) u_rd_port (
            .ra_i       (ra_w[gi]),
            .stored_i   (regs_q[ra_w[gi]]),
            .busy_bit_i (busy_q[ra_w[gi]]),
            .we0_i      (bus.WE0),
            .wa0_i      (bus.WA0),
            .wd0_i      (bus.WD0),
            .we1_i      (bus.WE1),
            .wa1_i      (bus.WA1),
            .wd1_i      (bus.WD1),
            .rd_o       (rd_w[gi]),
            .busy_o     (busy_w[gi])
        );
    end

    assign bus.RD    = rd_w;
    assign bus.BUSY  = busy_w;
    assign bus.STALL = |busy_w;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_sb : table-driven check of a BYPASS=1 and a BYPASS=0       |
// |                 regfile_sb driven with identical stimulus             |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int NRP   = 2;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NRP(NRP)) bus_b ();
    regfile_sb_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NRP(NRP)) bus_n ();

    regfile_sb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NRP(NRP), .BYPASS(1)) dut_b (
        .CLK   (clk),
        .aRSTn (rstn),
        .bus   (bus_b)
    );

    regfile_sb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NRP(NRP), .BYPASS(0)) dut_n (
        .CLK   (clk),
        .aRSTn (rstn),
        .bus   (bus_n)
    );

    typedef struct {
        logic        we0;
        reg_addr_t   wa0;
        logic [31:0] wd0;
        logic        we1;
        reg_addr_t   wa1;
        logic [31:0] wd1;
        logic        iss;
        reg_addr_t   ird;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  busy;
        logic [31:0] rd0_nb;
        logic [1:0]  busy_nb;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic drive(input logic we0, input reg_addr_t wa0, input logic [31:0] wd0,
                         input logic we1, input reg_addr_t wa1, input logic [31:0] wd1,
                         input logic iss, input reg_addr_t ird,
                         input reg_addr_t ra0, input reg_addr_t ra1);
        bus_b.WE0 = we0;  bus_b.WA0 = wa0;  bus_b.WD0 = wd0;
        bus_b.WE1 = we1;  bus_b.WA1 = wa1;  bus_b.WD1 = wd1;
        bus_b.ISSUE_EN = iss;  bus_b.ISSUE_RD = ird;
        bus_b.RA[0] = ra0;  bus_b.RA[1] = ra1;
        bus_n.WE0 = we0;  bus_n.WA0 = wa0;  bus_n.WD0 = wd0;
        bus_n.WE1 = we1;  bus_n.WA1 = wa1;  bus_n.WD1 = wd1;
        bus_n.ISSUE_EN = iss;  bus_n.ISSUE_RD = ird;
        bus_n.RA[0] = ra0;  bus_n.RA[1] = ra1;
    endtask

    task automatic idle(input reg_addr_t ra0, input reg_addr_t ra1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | iss ird | ra0 ra1 || rd0 rd1 busy | rd0_nb busy_nb
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd4,  5'd0,
                     32'h0,        32'h0,  2'b00, 32'h0,        2'b00};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd31, 5'd17,
                     32'h0,        32'h0,  2'b00, 32'h0,        2'b00};
        vecs[2]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5,  5'd6,
                     32'hDEADBEEF, 32'h0,  2'b00, 32'h0,        2'b00};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5,  5'd5,
                     32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[4]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7,  5'd7,
                     32'h22,       32'h22, 2'b00, 32'h0,        2'b00};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7,  5'd7,
                     32'h22,       32'h22, 2'b00, 32'h22,       2'b00};
        vecs[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0,  5'd0,
                     32'h0,        32'h0,  2'b00, 32'h0,        2'b00};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0,  5'd0,
                     32'h0,        32'h0,  2'b00, 32'h0,        2'b00};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  5'd3,
                     32'h0,        32'h0,  2'b00, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd2,  5'd3,
                     32'h0,        32'h0,  2'b10, 32'h0,        2'b10};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3,  5'd3,
                     32'h33,       32'h33, 2'b00, 32'h0,        2'b11};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd3,
                     32'h33,       32'h33, 2'b00, 32'h33,       2'b00};
        vecs[12] = '{1'b1, 5'd3, 32'h44,       1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3,  5'd8,
                     32'h44,       32'h0,  2'b00, 32'h33,       2'b00};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd3,
                     32'h44,       32'h44, 2'b11, 32'h44,       2'b11};
        vecs[14] = '{1'b1, 5'd3, 32'h55,       1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd3,  5'd9,
                     32'h55,       32'h99, 2'b00, 32'h44,       2'b01};
        vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3,  5'd9,
                     32'h55,       32'h99, 2'b00, 32'h55,       2'b00};

        // Reset with a write and an issue pending; both must be ignored.
        rstn = 1'b0;
        drive(1'b1, 5'd4, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(5'd0, 5'd0);

        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            idle(reg_addr_t'(a), reg_addr_t'(DEPTH - 1 - a));
            #2;
            chk($sformatf("rst rd0 a%0d", a), bus_b.RD[0], 32'h0);
            chk($sformatf("rst rd1 a%0d", a), bus_b.RD[1], 32'h0);
            chk($sformatf("rst stall a%0d", a), {31'h0, bus_b.STALL}, 32'h0);
            chk($sformatf("rst nb stall a%0d", a), {31'h0, bus_n.STALL}, 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we0, vecs[i].wa0, vecs[i].wd0, vecs[i].we1, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].iss, vecs[i].ird, vecs[i].ra0, vecs[i].ra1);
            #2;
            chk($sformatf("v%0d rd0", i), bus_b.RD[0], vecs[i].rd0);
            chk($sformatf("v%0d rd1", i), bus_b.RD[1], vecs[i].rd1);
            chk($sformatf("v%0d busy", i), {30'h0, bus_b.BUSY}, {30'h0, vecs[i].busy});
            chk($sformatf("v%0d stall", i), {31'h0, bus_b.STALL}, {31'h0, |vecs[i].busy});
            chk($sformatf("v%0d nb rd0", i), bus_n.RD[0], vecs[i].rd0_nb);
            chk($sformatf("v%0d nb busy", i), {30'h0, bus_n.BUSY}, {30'h0, vecs[i].busy_nb});
            chk($sformatf("v%0d nb stall", i), {31'h0, bus_n.STALL}, {31'h0, |vecs[i].busy_nb});
        end

        // Issue x9, then reset mid-operation with a write and issue that must be dropped.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        #2;
        chk("x9 issue busy", {30'h0, bus_b.BUSY}, 32'h0);
        @(negedge clk);
        idle(5'd9, 5'd9);
        #2;
        chk("x9 busy", {30'h0, bus_b.BUSY}, 32'h3);
        chk("x9 stall", {31'h0, bus_b.STALL}, 32'h1);
        chk("x9 rd0", bus_b.RD[0], 32'h99);
        @(negedge clk);
        rstn = 1'b0;
        drive(1'b1, 5'd9, 32'hAB, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd9, 5'd12);
        @(negedge clk);
        rstn = 1'b1;
        idle(5'd9, 5'd12);
        #2;
        chk("post-rst x9 rd0", bus_b.RD[0], 32'h0);
        chk("post-rst x12 rd1", bus_b.RD[1], 32'h0);
        chk("post-rst busy", {30'h0, bus_b.BUSY}, 32'h0);
        chk("post-rst stall", {31'h0, bus_b.STALL}, 32'h0);
        chk("post-rst nb busy", {30'h0, bus_n.BUSY}, 32'h0);
        chk("post-rst nb rd0", bus_n.RD[0], 32'h0);
        @(negedge clk);
        idle(5'd3, 5'd5);
        #2;
        chk("post-rst x3", bus_b.RD[0], 32'h0);
        chk("post-rst x5", bus_b.RD[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
